// File: rtl/bnn_pkg.sv
// Shared definitions for the binarized dense pipeline (784 -> 8 -> 10):
// layer widths, counter width, the "no class" code and a lowest-set-bit
// decoder used to turn a result vector into a class index.
package bnn_pkg;

  localparam int unsigned WIDTH0 = 784;
  localparam int unsigned WIDTH1 = 8;
  localparam int unsigned WIDTH2 = 10;
  localparam int unsigned CNT_W  = 16;

  typedef logic [3:0] class_t;

  localparam class_t CLASS_NONE = 4'hF;

  // Index of the lowest set bit; CLASS_NONE when no bit is set.
  // Meaningful for vectors of up to 15 bits (index 15 aliases CLASS_NONE).
  function automatic class_t lsb_index(input logic [15:0] vec);
    class_t idx;
    idx = CLASS_NONE;
    // Scan downwards so the lowest set bit is the last one written.
    for (int unsigned i = 16; i > 0; i--) begin
      if (vec[i-1]) idx = class_t'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bnn_res_fifo.sv
// Result FIFO for the final-stage vectors.
//   clk, rst      : clock, asynchronous active-low reset
//   clr           : synchronous clear (empties the FIFO, wins over push/pop)
//   push, din     : write din when not full
//   pop, dout     : dout shows the head; pop removes it when not empty
//   full, empty   : occupancy flags
//   count         : number of stored entries (0..DEPTH)
module bnn_res_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (cnt_q == CNT_MAX);
    empty   = (cnt_q == '0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    dout    = mem[rd_ptr];
    count   = cnt_q;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bnn_pipe_ctrl.sv
// Flow controller for the two-stage binarized dense pipeline.
// Accepts images on in_valid/in_ready, issues load enables for the stage-1
// (ld1) and stage-2 (ld2) datapath registers, tracks which stages hold live
// data, stalls on output backpressure and queues the stage-2 results in a
// small FIFO whose head is decoded into a class index.
//   clk, rst             : clock, asynchronous active-low reset
//   flush                : synchronous clear of valids and FIFO
//   in_valid / in_ready  : image handshake
//   ld1, ld2             : stage register load enables
//   res_in               : current stage-2 register contents
//   out_valid/out_ready  : result handshake; out_vec is the FIFO head
//   out_class, out_none  : lowest-set-bit index of out_vec / out_vec == 0
//   busy                 : any live data in the pipeline or FIFO
//   cnt_in, cnt_out      : wrapping accepted-image / popped-result counters
module bnn_pipe_ctrl #(
  parameter int unsigned WIDTH2 = bnn_pkg::WIDTH2,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = bnn_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ld1,
  output logic              ld2,
  input  logic [WIDTH2-1:0] res_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH2-1:0] out_vec,
  output logic [3:0]        out_class,
  output logic              out_none,
  output logic              busy,
  output logic [CNT_W-1:0]  cnt_in,
  output logic [CNT_W-1:0]  cnt_out
);

  import bnn_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic                   v1;
  logic                   v2;
  logic                   v1_nxt;
  logic                   v2_nxt;
  logic                   run;      // low during reset, high from the first edge after release
  logic                   mv2;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_cnt;
  logic [CNT_W-1:0]       cnt_in_q;
  logic [CNT_W-1:0]       cnt_out_q;

  bnn_res_fifo #(
    .WIDTH (WIDTH2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (push),
    .din   (res_in),
    .pop   (pop),
    .dout  (out_vec),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Handshake and load enables. Push is blocked while full even if the head
  // is popped this cycle: there is no same-cycle pass-through.
  always_comb begin
    mv2      = v2 & ~fifo_full;
    ld2      = ~flush & v1 & (~v2 | mv2);
    in_ready = run & ~flush & (~v1 | ld2);
    ld1      = in_valid & in_ready;
    push     = mv2 & ~flush;
    out_valid = ~fifo_empty;
    pop      = out_valid & out_ready;
    busy     = v1 | v2 | (fifo_cnt != '0);
    out_none = (out_vec == '0);
    out_class = lsb_index(16'(out_vec));
  end

  always_comb begin
    v1_nxt = v1;
    v2_nxt = v2;
    if (flush) begin
      v1_nxt = 1'b0;
      v2_nxt = 1'b0;
    end else begin
      if (ld1)      v1_nxt = 1'b1;
      else if (ld2) v1_nxt = 1'b0;
      if (ld2)      v2_nxt = 1'b1;
      else if (mv2) v2_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run <= 1'b0;
      v1  <= 1'b0;
      v2  <= 1'b0;
    end else begin
      run <= 1'b1;
      v1  <= v1_nxt;
      v2  <= v2_nxt;
    end
  end

  // Counters are not affected by flush; a pop during flush still counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_in_q  <= '0;
      cnt_out_q <= '0;
    end else begin
      if (ld1) cnt_in_q  <= cnt_in_q + CNT_ONE;
      if (pop) cnt_out_q <= cnt_out_q + CNT_ONE;
    end
  end

  assign cnt_in  = cnt_in_q;
  assign cnt_out = cnt_out_q;

endmodule

// File: tb/tb_bnn_pipe_ctrl.sv
// Directed bench for bnn_pipe_ctrl. A second, narrow-counter instance is
// used to exercise counter wrap-around without millions of cycles.
module tb_bnn_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        ld1;
  logic        ld2;
  logic [9:0]  res_in;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_vec;
  logic [3:0]  out_class;
  logic        out_none;
  logic        busy;
  logic [15:0] cnt_in;
  logic [15:0] cnt_out;

  logic        in_valid_s;
  logic        in_ready_s;
  logic        ld1_s;
  logic        ld2_s;
  logic        out_valid_s;
  logic [9:0]  out_vec_s;
  logic [3:0]  out_class_s;
  logic        out_none_s;
  logic        busy_s;
  logic [2:0]  cnt_in_s;
  logic [2:0]  cnt_out_s;

  // Emulated datapath registers fed by the load enables.
  logic [9:0]  img;
  logic [9:0]  s1;
  logic [9:0]  s2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bnn_pipe_ctrl #(.WIDTH2(10), .DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .ld1(ld1), .ld2(ld2),
    .res_in(res_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .out_class(out_class), .out_none(out_none),
    .busy(busy), .cnt_in(cnt_in), .cnt_out(cnt_out)
  );

  bnn_pipe_ctrl #(.WIDTH2(10), .DEPTH(2), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(in_valid_s), .in_ready(in_ready_s), .ld1(ld1_s), .ld2(ld2_s),
    .res_in(10'h001), .out_valid(out_valid_s), .out_ready(1'b1),
    .out_vec(out_vec_s), .out_class(out_class_s), .out_none(out_none_s),
    .busy(busy_s), .cnt_in(cnt_in_s), .cnt_out(cnt_out_s)
  );

  always @(posedge clk) begin
    if (ld1) s1 <= img;
    if (ld2) s2 <= s1;
  end
  assign res_in = s2;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int popped;
    int accepts;
    logic [15:0] ci;
    logic [15:0] co;

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_valid_s = 1'b0; img = '0; s1 = '0; s2 = '0;

    // Reset state, with in_valid high to show nothing is accepted.
    #12;
    in_valid = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ld1", ld1, 0);
    chk("rst_ld2", ld2, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt_in", cnt_in, 0);
    chk("rst_cnt_out", cnt_out, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    #1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_busy", busy, 0);

    // Single image latency.
    in_valid = 1'b1; img = 10'b0000100000;
    #1;
    chk("t1_ld1", ld1, 1);
    chk("t1_in_ready", in_ready, 1);
    chk("t1_ld2_early", ld2, 0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t1_ld2", ld2, 1);
    chk("t1_ld1_off", ld1, 0);
    tick();
    #1;
    chk("t1_ld2_off", ld2, 0);
    chk("t1_ov_early", out_valid, 0);
    tick();
    #1;
    chk("t1_ov", out_valid, 1);
    chk("t1_vec", out_vec, 10'h020);
    chk("t1_class", out_class, 5);
    chk("t1_none", out_none, 0);
    chk("t1_cnt_in", cnt_in, 1);
    out_ready = 1'b1;
    tick();
    #1;
    chk("t1_cnt_out", cnt_out, 1);
    chk("t1_ov_after", out_valid, 0);
    chk("t1_busy", busy, 0);

    // Stream 20 images with out_ready held high.
    popped = 0;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1; img = 10'(k + 1);
      #1;
      chk("st_in_ready", in_ready, 1);
      chk("st_full", dut.u_fifo.full, 0);
      chk("st_ov", out_valid, (k >= 3) ? 1 : 0);
      if (k >= 3) begin
        chk("st_vec", out_vec, popped + 1);
        popped++;
      end
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("st_tail_ov", out_valid, 1);
      chk("st_tail_vec", out_vec, popped + 1);
      popped++;
      tick();
    end
    #1;
    chk("st_cnt_out", cnt_out, 21);
    chk("st_cnt_in", cnt_in, 21);
    chk("st_drained", out_valid, 0);

    // Backpressure: four accepts, then stall.
    out_ready = 1'b0;
    accepts = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; img = 10'(100 + accepts);
      #1;
      chk("bp_rdy", in_ready, (c < 4) ? 1 : 0);
      if (in_ready) accepts++;
      tick();
    end
    chk("bp_accepts", accepts, 4);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("bp_ov", out_valid, 1);
      chk("bp_vec", out_vec, 100 + j);
      tick();
    end
    #1;
    chk("bp_cnt_eq", cnt_in, cnt_out);
    chk("bp_cnt_out", cnt_out, 25);
    chk("bp_busy", busy, 0);

    // Class decode for an all-zero and a top-bit result.
    out_ready = 1'b0;
    in_valid = 1'b1; img = 10'h000;
    tick();
    img = 10'h200;
    tick();
    in_valid = 1'b0;
    tick();
    #1;
    chk("cls_ov", out_valid, 1);
    chk("cls_none", out_none, 1);
    chk("cls_none_idx", out_class, 4'hF);
    out_ready = 1'b1;
    tick();
    #1;
    chk("cls_vec9", out_vec, 10'h200);
    chk("cls_idx9", out_class, 9);
    chk("cls_none9", out_none, 0);
    tick();
    out_ready = 1'b0;

    // Flush with four items in flight.
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; img = 10'(50 + c);
      tick();
    end
    #1;
    chk("fl_stalled", in_ready, 0);
    chk("fl_busy_pre", busy, 1);
    ci = cnt_in; co = cnt_out;
    flush = 1'b1;
    #1;
    chk("fl_ld1", ld1, 0);
    chk("fl_ld2", ld2, 0);
    chk("fl_in_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("fl_busy", busy, 0);
    chk("fl_ov", out_valid, 0);
    chk("fl_cnt_in", cnt_in, ci);
    chk("fl_cnt_out", cnt_out, co);
    chk("fl_cnt_in_val", cnt_in, 31);

    // Asynchronous reset mid-stream.
    out_ready = 1'b1;
    in_valid = 1'b1; img = 10'h007;
    tick();
    tick();
    tick();
    #1;
    chk("ar_busy_pre", busy, 1);
    rst = 1'b0;
    #1;
    chk("ar_ov", out_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_cnt_in", cnt_in, 0);
    chk("ar_cnt_out", cnt_out, 0);
    chk("ar_in_ready", in_ready, 0);
    chk("ar_ld1", ld1, 0);
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    #1;
    chk("ar_rel_rdy", in_ready, 1);

    // Counter wrap on the 3-bit instance.
    for (int k = 0; k < 7; k++) begin
      in_valid_s = 1'b1;
      #1;
      chk("wr_rdy", in_ready_s, 1);
      chk("wr_ld1", ld1_s, 1);
      tick();
    end
    #1;
    chk("wr_cnt7", cnt_in_s, 3'd7);
    tick();
    #1;
    chk("wr_cnt0", cnt_in_s, 3'd0);
    chk("wr_ld2", ld2_s, 1);
    in_valid_s = 1'b0;
    tick();
    tick();
    #1;
    chk("wr_ov", out_valid_s, 1);
    chk("wr_vec", out_vec_s, 10'h001);
    chk("wr_class", out_class_s, 0);
    chk("wr_none", out_none_s, 0);
    tick();
    #1;
    chk("wr_cnt_out0", cnt_out_s, 3'd0);
    chk("wr_busy", busy_s, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bnn_pipe_ctrl.md
# bnn_pipe_ctrl

Flow controller for the two-stage binarized dense pipeline (784→8→10). It accepts one input image per cycle on a valid/ready handshake and drives per-stage load enables for the stage-1 and stage-2 pipeline registers. It tracks which stages hold live data, stalls the pipeline under output backpressure, and buffers final 10-bit results in a small FIFO with a class-index decode. It sits between the image source and the result consumer; the dense stages and their registers stay in the datapath.

## Interface
- WIDTH2, default 10: result vector width.
- DEPTH, default 2: result FIFO entries; power of two, ≥2.
- CNT_W, default 16: image and result counter width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- flush  in  1  synchronous clear of pipeline valids and FIFO.
- in_valid  in  1  source presents an image on the datapath input.
- in_ready  out  1  controller accepts the image this cycle.
- ld1  out  1  load enable for the stage-1 register (8 bits).
- ld2  out  1  load enable for the stage-2 register (10 bits).
- res_in  in  WIDTH2  current stage-2 register contents.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer takes the head.
- out_vec  out  WIDTH2  FIFO head vector.
- out_class  out  4  index of the lowest set bit of out_vec; 4'hF if none set.
- out_none  out  1  out_vec == 0.
- busy  out  1  v1 | v2 | out_valid.
- cnt_in  out  CNT_W  images accepted, wraps.
- cnt_out  out  CNT_W  results popped, wraps.

## Operation
- State: v1 (stage-1 live), v2 (stage-2 live), FIFO pointers and count, and two counters.
- `mv2 = v2 & ~full`: stage 2 writes res_in into the FIFO at this edge.
- `ld2 = ~flush & v1 & (~v2 | mv2)`.
- `in_ready = ~flush & (~v1 | ld2)`.
- `ld1 = in_valid & in_ready`.
- v1 next: `ld1 ? 1 : (ld2 ? 0 : v1)`.
- v2 next: `ld2 ? 1 : (mv2 ? 0 : v2)`.
- When ld1 and ld2 are both high, both stages load on the same edge.
- FIFO push occurs on mv2 and is suppressed by flush.
- FIFO pop occurs on `out_valid & out_ready`.
- Push and pop can happen in the same cycle. When the FIFO is full, push is blocked even if a pop occurs that cycle; there is no same-cycle pass-through.
- Pointers wrap modulo DEPTH.
- out_class and out_none are combinational from out_vec.
- cnt_in increments on ld1 and cnt_out increments on pop. Both wrap at 2^CNT_W and neither is cleared by flush.
- flush takes priority over everything else:
  - the next state has v1 = v2 = 0 and an empty FIFO;
  - ld1, ld2 and in_ready are 0 during the flush cycle;
  - a pop in the flush cycle still counts.
- No FSM beyond the valid bits; the pipeline is fully elastic.

## Timing
- While rst is low, and after its release:
  - v1 = v2 = 0, FIFO empty, counters 0;
  - out_valid = 0, busy = 0;
  - in_ready = ld1 = ld2 = 0 while rst is low;
  - in_ready = 1 from the first cycle after release.
- Latency, no backpressure:
  - the image is accepted at edge E;
  - stage 1 loads at E, stage 2 loads at E+1, the FIFO push happens at E+2;
  - out_valid is high in the cycle after E+2 (3 cycles).
- Throughput is 1 image per cycle when out_ready is held at 1. With DEPTH = 2 the FIFO count stays ≤1 in that case.
- Backpressure (out_ready = 0):
  - the FIFO fills after DEPTH results;
  - v2 then holds, v1 holds, and in_ready drops;
  - the pipeline holds at most DEPTH + 2 results in flight;
  - no result is lost or duplicated.
- Reset mid-operation: all in-flight data is discarded and the outputs take their reset values immediately (asynchronous assertion).

## Structure
- Shared package bnn_pkg:
  - WIDTH0 = 784, WIDTH1 = 8, WIDTH2 = 10;
  - CNT_W = 16;
  - CLASS_NONE = 4'hF;
  - a function for lowest-set-bit index.
- One sub-module, bnn_res_fifo: a DEPTH × WIDTH2 FIFO with push, pop, full, empty and count.
- The controller logic lives in the top-level file.

## Test plan
- Reset release, then in_valid = 1 for one image with res_in = 10'b0000100000:
  - in_ready = 1 and ld1 pulses at the accept edge;
  - ld2 pulses one cycle later;
  - out_valid rises 3 cycles after accept with out_class = 5 and cnt_in = 1.
- Stream 20 images back-to-back with out_ready = 1:
  - in_ready stays 1 and the FIFO never reaches full;
  - 20 results appear in order, 1 per cycle;
  - cnt_out = 20.
- out_ready = 0 with continuous input:
  - in_ready drops after DEPTH + 2 = 4 accepts;
  - then raise out_ready: results 1–4 pop in order, the stall releases, cnt_in = cnt_out at the end.
- Drive res_in = 0 → out_none = 1 and out_class = 4'hF. Drive res_in = 10'h200 → out_class = 9.
- Assert flush with 4 items in flight:
  - the next cycle has busy = 0 and out_valid = 0;
  - counters are unchanged;
  - ld1 = 0 during the flush cycle even with in_valid = 1.
- Drive rst low mid-stream → all outputs take their reset values asynchronously. Preload the counters at 16'hFFFF → they wrap to 0 on the next increment.
